// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [1:0] MUX_IDLE = 2'd0;
  localparam logic [1:0] MUX_DATA = 2'd1;
  localparam logic [1:0] MUX_STOP = 2'd2;

  localparam int         DATA_BITS    = 8;
  localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_tx_controller_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module uart_tx_controller_bit_timer #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic period_end_o
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;

  // Next count: held at zero while cleared, wraps at the end of each bit period.
  always_comb begin
    baud_cnt_d = baud_cnt_q + 1'b1;
    if (clear_i || (baud_cnt_q == LAST)) begin
      baud_cnt_d = '0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud_cnt_q <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
    end
  end

  assign period_end_o = (baud_cnt_q == LAST);

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: accepts a byte per handshake and drives the
// load/enable/mux controls of the PISO datapath for one framed character.
//
// state | meaning
// IDLE  | line idle, ready for a byte
// LOAD  | one cycle: parallel-load shift register (start bit at its LSB)
// START | start bit on the line
// DATA  | data bits LSB-first, bit_idx selects the current one
// STOP  | stop bit(s), stop_cnt counts them
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic [7:0] data_out_o,
  output logic       load_o,
  output logic       en_reg_o,
  output logic [1:0] en_mux_o,
  output logic       idle_o,
  output logic       stop_o,
  output logic       busy_o,
  output logic       tx_done_o
);

  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t  state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic [7:0] data_q, data_d;
  logic       period_end;
  logic       timer_clear;

  uart_tx_controller_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (timer_clear),
    .period_end_o(period_end)
  );

  // Next-state and control outputs; reset forces the idle output values immediately.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    data_d      = data_q;
    load_o      = 1'b0;
    en_reg_o    = 1'b0;
    en_mux_o    = MUX_IDLE;
    tx_ready_o  = 1'b0;
    busy_o      = 1'b1;
    tx_done_o   = 1'b0;
    timer_clear = 1'b0;

    case (state_q)
      IDLE: begin
        tx_ready_o  = 1'b1;
        busy_o      = 1'b0;
        timer_clear = 1'b1;
        if (tx_valid_i) begin
          data_d  = tx_data_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_o      = 1'b1;
        en_reg_o    = 1'b1;
        timer_clear = 1'b1;
        state_d     = START;
      end
      START: begin
        en_mux_o = MUX_DATA;
        if (period_end) begin
          en_reg_o  = 1'b1;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        en_mux_o = MUX_DATA;
        if (period_end) begin
          if (bit_idx_q != LAST_BIT_IDX) begin
            en_reg_o  = 1'b1;
            bit_idx_d = bit_idx_q + 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            state_d    = STOP;
          end
        end
      end
      STOP: begin
        en_mux_o = MUX_STOP;
        if (period_end) begin
          if (stop_cnt_q != LAST_STOP) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else begin
            tx_done_o = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst_i) begin
      load_o     = 1'b0;
      en_reg_o   = 1'b0;
      en_mux_o   = MUX_IDLE;
      tx_ready_o = 1'b1;
      busy_o     = 1'b0;
      tx_done_o  = 1'b0;
    end
  end

  // State, counters and latched byte with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      data_q     <= data_d;
    end
  end

  assign data_out_o = data_q;
  assign idle_o     = 1'b1;
  assign stop_o     = 1'b1;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Bench for uart_tx_controller: three instances (4 clk/bit 1 stop, 4 clk/bit
// 2 stop, 2 clk/bit 1 stop) each feeding a small PISO datapath model; the line
// is compared against a frame computed from the byte and the bit period.
module tb_uart_tx_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v, valid_v;
  logic [7:0] data_v [3];
  logic [2:0] ready_v, load_v, enreg_v, idle_v, stop_v, busy_v, done_v, ser_v;
  logic [1:0] mux_v  [3];
  logic [7:0] dout_v [3];

  int errors = 0;
  int checks = 0;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [8:0] sh = 9'h1FF;

      uart_tx_controller #(
        .CLKS_PER_BIT(g == 2 ? 2 : 4),
        .STOP_BITS   (g == 1 ? 2 : 1)
      ) u_dut (
        .clk_i     (clk),
        .rst_i     (rst_v[g]),
        .tx_valid_i(valid_v[g]),
        .tx_data_i (data_v[g]),
        .tx_ready_o(ready_v[g]),
        .data_out_o(dout_v[g]),
        .load_o    (load_v[g]),
        .en_reg_o  (enreg_v[g]),
        .en_mux_o  (mux_v[g]),
        .idle_o    (idle_v[g]),
        .stop_o    (stop_v[g]),
        .busy_o    (busy_v[g]),
        .tx_done_o (done_v[g])
      );

      always @(posedge clk) begin
        if (enreg_v[g]) sh <= load_v[g] ? {dout_v[g], 1'b0} : {1'b1, sh[8:1]};
      end

      assign ser_v[g] = (mux_v[g] == 2'd0) ? idle_v[g] :
                        (mux_v[g] == 2'd1) ? sh[0] :
                        (mux_v[g] == 2'd2) ? stop_v[g] : 1'bx;
    end
  endgenerate

  // Send one byte on instance inst and check the whole frame cycle by cycle.
  task automatic run_frame(input int inst, input logic [7:0] b, input bit keep_valid,
                           input logic [7:0] next_b, input bit glitch, output int waited);
    int cpb, sb, total, bitpos;
    int bad_ser, bad_mux, n_en, n_load, load_k, n_done, done_k, bad_busy, bad_dout;
    logic exp_bit;
    logic [1:0] exp_mux;
    bit accepted;
    cpb   = (inst == 2) ? 2 : 4;
    sb    = (inst == 1) ? 2 : 1;
    total = (9 + sb) * cpb + 1;
    data_v[inst]  = b;
    valid_v[inst] = 1'b1;
    waited   = 0;
    accepted = 0;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      if (ready_v[inst] === 1'b1) accepted = 1;
      else waited++;
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL accept inst%0d: tx_ready stayed %b, required 1", inst, ready_v[inst]);
      valid_v[inst] = 1'b0;
      return;
    end
    bad_ser = 0; bad_mux = 0; n_en = 0; n_load = 0; load_k = -1;
    n_done = 0; done_k = -1; bad_busy = 0; bad_dout = 0;
    if (ser_v[inst] !== 1'b1) bad_ser++;
    if (mux_v[inst] !== 2'd0) bad_mux++;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == 1) begin
        exp_bit = 1'b1;
        exp_mux = 2'd0;
      end else begin
        bitpos  = (k - 2) / cpb;
        exp_bit = (bitpos == 0) ? 1'b0 : (bitpos <= 8) ? b[bitpos-1] : 1'b1;
        exp_mux = (bitpos <= 8) ? 2'd1 : 2'd2;
      end
      if (ser_v[inst] !== exp_bit) bad_ser++;
      if (mux_v[inst] !== exp_mux) bad_mux++;
      if (enreg_v[inst] === 1'b1) n_en++;
      if (load_v[inst] === 1'b1) begin n_load++; load_k = k; end
      if (done_v[inst] === 1'b1) begin n_done++; done_k = k; end
      if (busy_v[inst] !== 1'b1 || ready_v[inst] !== 1'b0) bad_busy++;
      if (dout_v[inst] !== b) bad_dout++;
      if (k == 1) begin
        if (keep_valid) data_v[inst] = next_b;
        else valid_v[inst] = 1'b0;
      end
      if (glitch && k == 2 + 4 * cpb) begin
        data_v[inst]  = ~b;
        valid_v[inst] = 1'b1;
      end
      if (glitch && k == 3 + 4 * cpb) valid_v[inst] = 1'b0;
    end
    checks++;
    if (bad_ser != 0) begin errors++;
      $display("FAIL serial inst%0d byte %h: %0d wrong line cycles, required 0", inst, b, bad_ser); end
    checks++;
    if (bad_mux != 0) begin errors++;
      $display("FAIL en_mux inst%0d byte %h: %0d wrong cycles, required 0", inst, b, bad_mux); end
    checks++;
    if (n_en != 9) begin errors++;
      $display("FAIL en_reg_count inst%0d: got %0d, required 9", inst, n_en); end
    checks++;
    if (n_load != 1 || load_k != 1) begin errors++;
      $display("FAIL load inst%0d: count %0d at k=%0d, required 1 at k=1", inst, n_load, load_k); end
    checks++;
    if (n_done != 1 || done_k != total) begin errors++;
      $display("FAIL tx_done inst%0d: count %0d at k=%0d, required 1 at k=%0d", inst, n_done, done_k, total); end
    checks++;
    if (bad_busy != 0) begin errors++;
      $display("FAIL busy_ready inst%0d: %0d wrong cycles, required 0", inst, bad_busy); end
    checks++;
    if (bad_dout != 0) begin errors++;
      $display("FAIL data_out inst%0d byte %h: %0d unstable cycles, required 0", inst, b, bad_dout); end
  endtask

  task automatic test_reset();
    rst_v   = 3'b111;
    valid_v = 3'b000;
    for (int i = 0; i < 3; i++) data_v[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mux_v[i] !== 2'd0 || ready_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || load_v[i] !== 1'b0 ||
          enreg_v[i] !== 1'b0 || dout_v[i] !== 8'h00 || done_v[i] !== 1'b0 ||
          idle_v[i] !== 1'b1 || stop_v[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset inst%0d: mux=%0d rdy=%b busy=%b load=%b en=%b dout=%h done=%b idle=%b stop=%b, required 0 1 0 0 0 00 0 1 1",
                 i, mux_v[i], ready_v[i], busy_v[i], load_v[i], enreg_v[i], dout_v[i], done_v[i], idle_v[i], stop_v[i]);
      end
    end
    rst_v = 3'b000;
  endtask

  task automatic test_single();
    int w;
    run_frame(0, 8'hA5, 0, 8'h00, 0, w);
    @(negedge clk);
    checks++;
    if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin errors++;
      $display("FAIL ready_after_done: rdy=%b busy=%b, required 1 0", ready_v[0], busy_v[0]); end
  endtask

  task automatic test_stop2();
    int w;
    run_frame(1, 8'h3C, 0, 8'h00, 0, w);
  endtask

  task automatic test_cpb2();
    int w;
    run_frame(2, 8'h96, 0, 8'h00, 0, w);
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    run_frame(0, 8'h00, 1, 8'hFF, 0, w1);
    run_frame(0, 8'hFF, 0, 8'h00, 0, w2);
    checks++;
    if (w2 != 0) begin errors++;
      $display("FAIL back_to_back: second accept %0d cycles late, required 0", w2); end
  endtask

  task automatic test_busy_ignore();
    int w;
    run_frame(0, 8'h5A, 0, 8'h00, 1, w);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int w, bad_done, bad_rdy;
    bit accepted;
    b = 8'($urandom) | 8'h01;
    data_v[0]  = b;
    valid_v[0] = 1'b1;
    accepted = 0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (ready_v[0] === 1'b1) accepted = 1;
    end
    checks++;
    if (!accepted) begin errors++;
      $display("FAIL reset_mid_accept: tx_ready=%b, required 1", ready_v[0]); end
    bad_done = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) bad_done++;
      if (k == 1) valid_v[0] = 1'b0;
    end
    rst_v[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_v[0] !== 1'b1 || mux_v[0] !== 2'd0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 ||
        dout_v[0] !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b mux=%0d busy=%b done=%b dout=%h, required 1 0 0 0 00",
               ready_v[0], mux_v[0], busy_v[0], done_v[0], dout_v[0]);
    end
    rst_v[0] = 1'b0;
    bad_rdy = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) bad_done++;
      if (ready_v[0] !== 1'b1 || mux_v[0] !== 2'd0) bad_rdy++;
    end
    checks++;
    if (bad_done != 0 || bad_rdy != 0) begin errors++;
      $display("FAIL reset_mid_quiet: tx_done cycles %0d, non-idle cycles %0d, required 0 0", bad_done, bad_rdy); end
    run_frame(0, 8'($urandom), 0, 8'h00, 0, w);
  endtask

  task automatic test_random();
    int inst, w, gap;
    logic [7:0] b;
    for (int i = 0; i < 9; i++) begin
      inst = i % 3;
      b    = 8'($urandom);
      gap  = int'($urandom_range(0, 5));
      repeat (gap) @(negedge clk);
      run_frame(inst, b, 0, 8'h00, 0, w);
      @(negedge clk);
      checks++;
      if (ready_v[inst] !== 1'b1) begin errors++;
        $display("FAIL random_ready inst%0d: tx_ready=%b, required 1", inst, ready_v[inst]); end
    end
  endtask

  initial begin
    rst_v   = 3'b111;
    valid_v = 3'b000;
    for (int i = 0; i < 3; i++) data_v[i] = 8'h00;
    test_reset();
    @(negedge clk);
    test_single();
    test_stop2();
    test_cpb2();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
